// File: rtl/divider_restored.sv
// Sequential unsigned restoring divider: one shift-and-subtract step per clock.
// Optional build macro DIV_ZERO_DETECT_EN short-circuits B==0 straight to completion.
module divider_restored #(
  parameter int tamano = 8
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              START,
  input  logic [tamano-1:0] A,
  input  logic [tamano-1:0] B,
  output logic [tamano-1:0] Q,
  output logic [tamano-1:0] R,
  output logic              END_DIV,
  output logic              BUSY,
  output logic              DIV_BY_ZERO
);

  localparam int CW = $clog2(tamano + 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t            state_q, state_d;
  logic [tamano:0]   p_q, p_d;
  logic [tamano-1:0] x_q, x_d;
  logic [tamano-1:0] m_q, m_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [tamano-1:0] q_q, q_d;
  logic [tamano-1:0] r_q, r_d;
  logic              end_q, end_d;
  logic              busy_q, busy_d;
  logic [tamano:0]   p_sh, t;
  logic [tamano-1:0] x_sh;
`ifdef DIV_ZERO_DETECT_EN
  logic              dbz_q, dbz_d;
`endif

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    x_d     = x_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    end_d   = 1'b0;
    busy_d  = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    dbz_d   = 1'b0;
`endif
    p_sh = {p_q[tamano-1:0], x_q[tamano-1]};
    x_sh = {x_q[tamano-2:0], 1'b0};
    t    = p_sh - {1'b0, m_q};

    case (state_q)
      IDLE: begin
        busy_d = START;
        if (START) begin
          x_d     = A;
          m_d     = B;
          p_d     = '0;
          cnt_d   = CW'(tamano);
          state_d = ITER;
`ifdef DIV_ZERO_DETECT_EN
          if (B == '0) begin
            q_d     = '1;
            r_d     = A;
            state_d = DONE;
          end
`endif
        end
      end
      ITER: begin
        busy_d = 1'b1;
        // A borrow out of the tamano+1 bit difference means the divisor did not fit: keep the shifted remainder.
        if (!t[tamano]) begin
          p_d = t;
          x_d = x_sh | {{(tamano-1){1'b0}}, 1'b1};
        end else begin
          p_d = p_sh;
          x_d = x_sh;
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d     = x_d;
          r_d     = p_d[tamano-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b1;
        end_d   = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
        dbz_d   = (m_q == '0);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      p_q     <= '0;
      x_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      x_q     <= x_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign Q       = q_q;
  assign R       = r_q;
  assign END_DIV = end_q;
  assign BUSY    = busy_q;
`ifdef DIV_ZERO_DETECT_EN
  assign DIV_BY_ZERO = dbz_q;
`else
  assign DIV_BY_ZERO = 1'b0;
`endif

endmodule

// File: tb/tb_divider_restored.sv
// Scoreboard bench for divider_restored: expected results queued at acceptance, checked on END_DIV.
module tb_divider_restored;

  localparam int W = 8;

  logic         CLOCK = 1'b0;
  logic         RESET = 1'b1;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Q, R;
  logic         END_DIV, BUSY, DIV_BY_ZERO;

  divider_restored #(.tamano(W)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .A(A), .B(B),
    .Q(Q), .R(R), .END_DIV(END_DIV), .BUSY(BUSY), .DIV_BY_ZERO(DIV_BY_ZERO)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int a, b, q, r, dbz, t0, lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_end = 1'b0;

`ifdef DIV_ZERO_DETECT_EN
  localparam bit ZDET = 1'b1;
`else
  localparam bit ZDET = 1'b0;
`endif

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int t0);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.q   = (b == 0) ? 255 : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.dbz = (b == 0 && ZDET) ? 1 : 0;
    e.lat = (b == 0 && ZDET) ? 1 : 9;
    e.t0  = t0;
    return e;
  endfunction

  always @(negedge CLOCK) begin
    if (!RESET && END_DIV) begin
      exp_t e;
      chk("end_pulse_width", prev_end, 0);
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q", Q, e.q);
        chk("r", R, e.r);
        chk("div_by_zero", DIV_BY_ZERO, e.dbz);
        chk("latency", cyc - e.t0, e.lat);
        chk("busy_at_end", BUSY, 1);
        if (e.b != 0) begin
          chk("inv_a_eq_qb_r", int'(Q) * e.b + int'(R), e.a);
          chk("inv_r_lt_b", R < e.b, 1);
        end
      end
    end
    prev_end = END_DIV;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge CLOCK);
    while (BUSY && n < 40) begin
      @(negedge CLOCK);
      n++;
    end
    if (n >= 40) chk("idle_timeout", BUSY, 0);
  endtask

  task automatic do_div(input int a, input int b);
    wait_idle();
    A = W'(a);
    B = W'(b);
    START = 1'b1;
    @(posedge CLOCK);
    #1;
    sb.push_back(model(a, b, cyc));
    START = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge CLOCK);
      #1;
      n++;
    end
    if (n >= 60) chk("done_timeout", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("rst_q", Q, 0);
    chk("rst_r", R, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_end", END_DIV, 0);
    chk("rst_dbz", DIV_BY_ZERO, 0);
    RESET = 1'b0;

    do_div(200, 7);
    @(negedge CLOCK);
    chk("busy_after_accept", BUSY, 1);
    wait_done();
    @(negedge CLOCK);
    chk("busy_after_end", BUSY, 0);
    chk("end_after_end", END_DIV, 0);

    do_div(255, 1);   wait_done();
    do_div(5, 9);     wait_done();
    do_div(255, 255); wait_done();
    do_div(0, 3);     wait_done();
    do_div(100, 0);   wait_done();

    // START during an operation must be ignored.
    do_div(50, 6);
    repeat (3) @(posedge CLOCK);
    #1;
    A = 8'd9;
    B = 8'd3;
    START = 1'b1;
    @(posedge CLOCK);
    #1;
    START = 1'b0;
    wait_done();
    repeat (5) begin
      @(negedge CLOCK);
      chk("hold_q", Q, 8);
      chk("hold_r", R, 2);
      chk("hold_end", END_DIV, 0);
    end

    // Reset sampled at edge 5 of a 200/7 run.
    do_div(200, 7);
    repeat (4) @(posedge CLOCK);
    #1;
    RESET = 1'b1;
    @(posedge CLOCK);
    @(negedge CLOCK);
    chk("midrst_q", Q, 0);
    chk("midrst_r", R, 0);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_end", END_DIV, 0);
    sb.delete();
    RESET = 1'b0;
    do_div(17, 5);
    wait_done();

    // START held high: back-to-back divisions 10 cycles apart.
    wait_idle();
    A = 8'd77;
    B = 8'd10;
    START = 1'b1;
    @(posedge CLOCK);
    #1;
    t0 = cyc;
    for (int k = 0; k < 3; k++) sb.push_back(model(77, 10, t0 + 10 * k));
    begin
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
        @(negedge CLOCK);
        #1;
        n++;
      end
      START = 1'b0;
      if (n >= 60) chk("held_timeout", sb.size(), 0);
    end
    repeat (3) @(negedge CLOCK);
    chk("held_no_extra_busy", BUSY, 0);

    for (int i = 0; i < 1000; i++) begin
      do_div(int'($urandom_range(0, 255)), int'($urandom_range(1, 255)));
      wait_done();
    end

    repeat (3) @(negedge CLOCK);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_restored.md
Name: divider_restored

Overview:
- Sequential unsigned restoring divider (shift-and-subtract), the inverse operation of the team's shift-and-add multiplier.
- Takes dividend A and divisor B on a START handshake; produces quotient Q and remainder R after tamano iterations; signals completion with END_DIV.
- Single FSM control path plus datapath (partial-remainder register, quotient shifter, subtractor, iteration counter) in one module.

Parameters:
tamano, 8, width in bits of dividend, divisor, quotient and remainder

Ports:
CLOCK  input  1  system clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
START  input  1  request; sampled only in IDLE
A  input  tamano  dividend, unsigned
B  input  tamano  divisor, unsigned
Q  output  tamano  quotient
R  output  tamano  remainder
END_DIV  output  1  one-cycle completion pulse; Q/R valid while high
BUSY  output  1  high from the edge accepting START until END_DIV deasserts
DIV_BY_ZERO  output  1  high with END_DIV when B was 0 (see optional feature)

Behaviour:
- Reset, applied on a rising edge with RESET=1, has priority over everything including mid-operation. It returns the FSM to IDLE and sets Q=0, R=0, END_DIV=0, BUSY=0, DIV_BY_ZERO=0, and all internal registers to 0.
- FSM states: IDLE, ITER, DONE.
- IDLE: at the edge with START=1, latch A into the quotient shifter X and B into divisor register M. Clear the partial remainder P (tamano+1 bits). Set counter = tamano. Go to ITER (BUSY=1). With START=0, stay in IDLE.
- ITER: each edge performs one iteration.
  - Shift {P,X} left by one; X MSB enters P LSB.
  - T = P_shifted - {1'b0,M}, computed tamano+1 bits wide.
  - If T[tamano]==0: P=T and X LSB=1. Otherwise P=P_shifted (restore) and X LSB=0.
  - Decrement counter. On the edge where the counter goes 1->0, load Q=X_new and R=P_new[tamano-1:0], and go to DONE.
- DONE: END_DIV=1, BUSY=1 for exactly one cycle, then go unconditionally to IDLE.
- Latency: START accepted at edge 0; END_DIV is high in the cycle following edge tamano+1 (9 cycles for tamano=8).
- Q and R are registered outputs. They hold their values after DONE until the next DONE or reset. They are not cleared when a new START is accepted.
- START while BUSY=1 is ignored, with no queuing. START held high continuously gives back-to-back divisions: a new one is accepted on the first IDLE edge after DONE.
- A and B may change after the accepting edge without effect.
- Arithmetic invariant for B!=0: A == Q*B + R and R < B.
- B=0 without the optional feature: the algorithm runs normally and yields Q = all ones and R = A. DIV_BY_ZERO stays 0.

Optional Feature:
- Macro: DIV_ZERO_DETECT_EN.
- Defined: at the accepting edge in IDLE, if B==0, skip ITER and go directly to DONE.
  - Load Q = all ones and R = A.
  - DIV_BY_ZERO=1 for the same cycle as END_DIV.
  - END_DIV is high in the cycle after edge 1.
  - For B!=0, behaviour is identical to the undefined case.
- Undefined: no zero check logic, DIV_BY_ZERO tied to 0, and B=0 takes the full tamano+1 latency with the results stated above.

Test Plan:
- A=200, B=7, START pulse at edge 0 -> END_DIV high after edge 9 for one cycle, Q=28, R=4, BUSY low after that cycle.
- Corner values, one division each:
  - A=255, B=1 -> Q=255, R=0.
  - A=5, B=9 -> Q=0, R=5.
  - A=255, B=255 -> Q=1, R=0.
  - A=0, B=3 -> Q=0, R=0.
- A=100, B=0 -> with DIV_ZERO_DETECT_EN: END_DIV after edge 1, Q=255, R=100, DIV_BY_ZERO=1. Without it: END_DIV after edge 9, Q=255, R=100, DIV_BY_ZERO=0.
- Ignored START and held results:
  - Start A=50, B=6, then pulse START with A=9, B=3 at edge 4 -> only 50/6 completes (Q=8, R=2).
  - Q/R then hold 8/2 through 5 idle cycles.
- Reset mid-operation: RESET=1 at edge 5 of a 200/7 run -> next cycle Q=0, R=0, BUSY=0, END_DIV=0, FSM in IDLE. A fresh START with A=17, B=5 -> Q=3, R=2 at normal latency.
- START held high for 3 operations with A=77, B=10 -> END_DIV pulses at 10-cycle spacing (9 + 1 IDLE acceptance), each with Q=7, R=7. Random sweep of 1000 operand pairs checks A==Q*B+R and R<B.
